instr_fetch_buffer: RTL and testbench

//  Fetch-side reader between the program counter and decode. Issues in-order

---
 rtl/instr_fetch_buffer_pkg.sv | 25 ++
 rtl/instr_fetch_buffer_chk.sv | 19 +
 rtl/instr_fetch_buffer_fifo.sv | 61 ++++++
 rtl/instr_fetch_buffer.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer: fetch FSM states,
// buffered entry layout and the sequential-PC helper.
package instr_fetch_buffer_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam logic [ADDR_W-1:0] PC_INC = 16'd2;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_chk.sv
// Protocol checks for the fetch buffer: memory responses only while reads are
// outstanding, and buffered plus outstanding reads never exceed the depth.
module instr_fetch_buffer_chk #(
    parameter int CDEPTH = 4,
    parameter int CNT_W  = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             imem_rvalid,
    input logic [CNT_W-1:0] inflight,
    input logic [CNT_W-1:0] count
);
    a_rvalid_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (inflight != {CNT_W{1'b0}}));

    a_occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, inflight} + {1'b0, count}) <= (CNT_W+1)'(CDEPTH));

endmodule

// File: rtl/instr_fetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear and an occupancy count.
// Clear wins over push/pop; the caller guarantees no push into a full FIFO.
module instr_fetch_buffer_fifo
    import instr_fetch_buffer_pkg::*;
#(
    parameter int FDEPTH = DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  fetch_entry_t                  push_data,
    input  logic                          pop,
    input  logic                          clear,
    output fetch_entry_t                  head,
    output logic [$clog2(FDEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(FDEPTH);
    localparam int CNT_W = $clog2(FDEPTH+1);

    fetch_entry_t             r_mem [FDEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FDEPTH-1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // Storage, pointers and count; storage is reset so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FDEPTH; i++) begin
                r_mem[i] <= '{pc: {ADDR_W{1'b0}}, instr: {INSTR_W{1'b0}}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch-side reader: issues in-order instruction reads, buffers responses with
// their PCs for decode, and handles branch redirect (flush + squash) and halt.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int FDEPTH = DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt_sys,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_addr,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic                          imem_rvalid,
    input  logic [INSTR_W-1:0]            imem_rdata,
    output logic                          ins_valid,
    output logic [INSTR_W-1:0]            ins_data,
    output logic [ADDR_W-1:0]             ins_pc,
    input  logic                          ins_ready,
    output logic [$clog2(FDEPTH+1)-1:0]   buf_count,
    output logic                          halted
);
    localparam int CNT_W = $clog2(FDEPTH+1);

    fetch_state_t        r_state;
    logic                r_halted;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [ADDR_W-1:0]   r_resp_pc;
    logic [CNT_W-1:0]    r_inflight;
    logic [CNT_W-1:0]    r_squash;

    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_occ;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    fetch_entry_t        w_head;
    fetch_entry_t        w_push_entry;

    // Buffered plus in-flight reads reserve a slot each, so a response always fits.
    assign w_occ        = {1'b0, w_count} + {1'b0, r_inflight};
    assign w_issue      = !rst && (r_state == ST_FETCH) && !redirect && !halt_sys &&
                          (w_occ < (CNT_W+1)'(FDEPTH));
    assign w_push       = imem_rvalid && !redirect && (r_squash == {CNT_W{1'b0}});
    assign w_pop        = ins_valid && ins_ready && !redirect;
    assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

    instr_fetch_buffer_fifo #(.FDEPTH(FDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .clear     (redirect),
        .head      (w_head),
        .count     (w_count)
    );

    // Fetch FSM: halt is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (halt_sys) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_FETCH;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Request and response PC tracking; redirect retargets both streams.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_addr <= {ADDR_W{1'b0}};
            r_resp_pc    <= {ADDR_W{1'b0}};
        end else if (redirect) begin
            r_fetch_addr <= redirect_addr;
            r_resp_pc    <= redirect_addr;
        end else begin
            if (w_issue) begin
                r_fetch_addr <= next_pc(r_fetch_addr);
            end
            if (w_push) begin
                r_resp_pc <= next_pc(r_resp_pc);
            end
        end
    end

    // Outstanding reads, and how many of them belong to a flushed stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= {CNT_W{1'b0}};
            r_squash   <= {CNT_W{1'b0}};
        end else begin
            case ({w_issue, imem_rvalid})
                2'b10:   r_inflight <= r_inflight + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_inflight <= r_inflight - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_inflight <= r_inflight;
            endcase
            if (redirect) begin
                r_squash <= r_inflight - CNT_W'(imem_rvalid);
            end else if (imem_rvalid && (r_squash != {CNT_W{1'b0}})) begin
                r_squash <= r_squash - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_squash <= r_squash;
            end
        end
    end

    instr_fetch_buffer_chk #(.CDEPTH(FDEPTH), .CNT_W(CNT_W)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .imem_rvalid (imem_rvalid),
        .inflight    (r_inflight),
        .count       (w_count)
    );

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_addr;
    assign ins_valid = (w_count != {CNT_W{1'b0}});
    assign ins_data  = w_head.instr;
    assign ins_pc    = w_head.pc;
    assign buf_count = w_count;
    assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level model (request queue with epochs, buffer queue).
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_sys = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready = 1'b0;
    logic [2:0]  buf_count;
    logic        halted;

    instr_fetch_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .halt_sys      (halt_sys),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .ins_valid     (ins_valid),
        .ins_data      (ins_data),
        .ins_pc        (ins_pc),
        .ins_ready     (ins_ready),
        .buf_count     (buf_count),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          tag;
        int          due;
    } req_t;

    // Model state
    req_t        pend[$];
    logic [15:0] bufq[$];
    int          epoch = 0;
    logic [15:0] exp_req_addr = 16'h0000;
    logic        halted_m = 1'b0;
    int          cyc = 0;
    logic        prev_rst = 1'b1;

    // Next-cycle stimulus
    logic        nx_rst = 1'b1;
    logic        nx_halt = 1'b0;
    logic        nx_redirect = 1'b0;
    logic [15:0] nx_raddr = 16'h0000;
    logic        nx_ready = 1'b1;
    int          lat = 1;
    int          throttle = 0;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a * 16'h0003) ^ 16'hC35A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic cycle();
        logic  rv;
        logic  exp_req;
        req_t  r;
        @(negedge clk);
        rst           = nx_rst;
        halt_sys      = nx_halt;
        redirect      = nx_redirect;
        redirect_addr = nx_raddr;
        ins_ready     = nx_ready;
        rv = !nx_rst && (pend.size() > 0) && (pend[0].due <= cyc) &&
             ($urandom_range(0, 99) >= throttle);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_f(pend[0].addr) : 16'($urandom);
        #1;
        exp_req = !nx_rst && !halted_m && !nx_redirect && !nx_halt &&
                  ((bufq.size() + pend.size()) < 4);
        if (nx_rst) begin
            if (prev_rst) begin
                chk("rst_imem_req", 32'(imem_req), 32'd0);
                chk("rst_imem_addr", 32'(imem_addr), 32'd0);
                chk("rst_ins_valid", 32'(ins_valid), 32'd0);
                chk("rst_ins_pc", 32'(ins_pc), 32'd0);
                chk("rst_ins_data", 32'(ins_data), 32'd0);
                chk("rst_buf_count", 32'(buf_count), 32'd0);
                chk("rst_halted", 32'(halted), 32'd0);
            end
            pend.delete();
            bufq.delete();
            epoch++;
            exp_req_addr = 16'h0000;
            halted_m = 1'b0;
        end else begin
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(exp_req_addr));
            chk("buf_count", 32'(buf_count), 32'(bufq.size()));
            chk("ins_valid", 32'(ins_valid), 32'(bufq.size() != 0));
            if (bufq.size() != 0) begin
                chk("ins_pc", 32'(ins_pc), 32'(bufq[0]));
                chk("ins_data", 32'(ins_data), 32'(mem_f(bufq[0])));
            end
            chk("halted", 32'(halted), 32'(halted_m));
            if (rv) r = pend.pop_front();
            if (nx_redirect) begin
                bufq.delete();
                epoch++;
                exp_req_addr = nx_raddr;
            end else begin
                if ((bufq.size() != 0) && nx_ready) void'(bufq.pop_front());
                if (rv && (r.tag == epoch)) bufq.push_back(r.addr);
            end
            if (exp_req) begin
                pend.push_back('{addr: exp_req_addr, tag: epoch, due: cyc + lat});
                exp_req_addr = exp_req_addr + 16'h0002;
            end
            if (nx_halt) halted_m = 1'b1;
        end
        prev_rst = nx_rst;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset, then streaming with latency 1 and decode always ready
        nx_rst = 1'b1; run(3);
        nx_rst = 1'b0; nx_ready = 1'b1; lat = 1; run(20);

        // Decode stalled: buffer fills to 4, then drains in order
        nx_ready = 1'b0; run(12);
        nx_ready = 1'b1; run(10);

        // Latency 3 with reads in flight, redirect to 0x0100
        lat = 3; run(6);
        nx_redirect = 1'b1; nx_raddr = 16'h0100; run(1);
        nx_redirect = 1'b0; run(15);

        // Redirect near top of address space: fetch wraps to 0x0000
        lat = 1;
        nx_redirect = 1'b1; nx_raddr = 16'hFFFC; run(1);
        nx_redirect = 1'b0; run(10);

        // Reset mid-stream, then refetch from 0
        nx_rst = 1'b1; run(2);
        nx_rst = 1'b0; run(10);

        // Randomized traffic: stalls, variable latency, throttled responses, redirects
        throttle = 30;
        for (int i = 0; i < 800; i++) begin
            nx_ready    = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 4);
            nx_redirect = ($urandom_range(0, 24) == 0);
            nx_raddr    = ($urandom_range(0, 3) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 3) * 2))
                                                     : (16'($urandom) & 16'hFFFE);
            cycle();
        end
        nx_redirect = 1'b0;

        // Halt with reads outstanding: buffered and in-flight data still drain
        throttle = 0; lat = 2; nx_ready = 1'b0; run(4);
        nx_halt = 1'b1; run(1);
        nx_halt = 1'b0; run(3);
        nx_ready = 1'b1; run(15);

        // Redirect while halted: flushes but stays halted
        nx_ready = 1'b0; run(2);
        nx_redirect = 1'b1; nx_raddr = 16'h0200; run(1);
        nx_redirect = 1'b0; run(6);

        // Reset releases halt
        nx_rst = 1'b1; run(2);
        nx_rst = 1'b0; nx_ready = 1'b1; run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
